spi_master_multi: RTL and testbench
===================================

Name: spi_master_multi

Overview:
Parametrised SPI master, successor to the fixed 8-bit single-slave master.
- Full-duplex shift of DATA_W bits, with a programmable SCK divider.
- All four SPI modes, selected per transfer by CPOL/CPHA.
- NUM_SS one-hot active-low slave selects.
- Sits between the system-clock control logic and external SPI slaves, with a start/busy/done handshake replacing the load/enOut scheme.

Parameters:
- DATA_W, 8: transfer width in bits (≥2).
- CLK_DIV, 2: clk cycles per SCK half-period (≥1).
- NUM_SS, 2: number of slave-select outputs (≥1).
- SEL_W, 1: width of ss_sel; must satisfy 2^SEL_W ≥ NUM_SS.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- start, input, 1: transfer request; sampled in IDLE only.
- tx_data, input, DATA_W: word to transmit; latched on accepted start.
- ss_sel, input, SEL_W: target slave index; latched on accepted start.
- cpol, input, 1: SCK idle level; latched on accepted start.
- cpha, input, 1: 0 = sample on leading edge, 1 = sample on trailing edge; latched on accepted start.
- miso, input, 1: serial data from slave.
- sck, output, 1: SPI clock.
- mosi, output, 1: serial data to slave, MSB first.
- ss_n, output, NUM_SS: active-low slave selects.
- busy, output, 1: high from the cycle after an accepted start until done.
- done, output, 1: one-cycle pulse when rx_data is valid.
- rx_data, output, DATA_W: last received word; held until the next done.

Behaviour:
- Reset values: sck=0, mosi=0, ss_n all 1, busy=0, done=0, rx_data=0, FSM=IDLE, divider and bit counters 0.
- Reset mid-transfer aborts immediately. No done pulse; rx_data is not updated.
- FSM states: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE:
  - sck register loads the cpol input every cycle.
  - start=1 → latch tx_data/ss_sel/cpol/cpha into the shift register and config.
  - Next cycle: busy=1, ss_n[ss_sel]=0, state=SETUP.
- SETUP: lasts CLK_DIV cycles; sck=latched cpol.
  - CPHA=0: mosi=tx bit DATA_W-1 from the first SETUP cycle.
  - CPHA=1: mosi is unchanged until the first edge.
- XFER:
  - Divider counts 0..CLK_DIV-1 and toggles sck on the terminal count.
  - Exactly 2*DATA_W edges; odd-numbered edges are leading, even-numbered are trailing.
  - CPHA=0: leading edge samples miso into the shift LSB; trailing edge shifts left and drives the next bit on mosi (no shift after the final edge).
  - CPHA=1: leading edge drives the next bit on mosi; trailing edge samples miso.
  - After edge 2*DATA_W, sck equals the latched cpol.
- HOLD:
  - CLK_DIV cycles with ss_n still asserted.
  - Then ss_n all 1, busy=0, rx_data←shift register, done=1 for one cycle, state=IDLE.
- Latency: done is high in the cycle (2*DATA_W+2)*CLK_DIV+1 clocks after the start-sampling edge. For DATA_W=8, CLK_DIV=2 this is 37.
- start while busy: ignored; no queueing.
- start held high: a new transfer is accepted in the first IDLE cycle after done, which gives back-to-back transfers.
- cpol/cpha/ss_sel/tx_data changes during busy: no effect.
- ss_sel ≥ NUM_SS: transfer runs normally with all ss_n held 1; done still pulses.
- mosi after done: holds its last value until the next transfer.

Optional Feature:
SPI_LSB_FIRST_EN
- Defined: adds input port lsb_first (1 bit), latched on accepted start. When 1, bit 0 is transmitted first and received bits shift in from the MSB end, so rx_data is bit-ordered identically to tx_data.
- Undefined: the port is absent and transfers are MSB first only.

Test Plan:
- Mode 0, DATA_W=8, CLK_DIV=2, ss_sel=0, tx 0xA5, slave model returns 0x3C:
  - mosi sequence 1,0,1,0,0,1,0,1, sampled on sck rising.
  - ss_n=2'b10 throughout the transfer.
  - done at cycle 37; rx_data=0x3C; sck idle 0.
- Mode 3 (cpol=1, cpha=1), tx 0x81, slave returns 0xFF:
  - sck idles 1; mosi changes on falling edges and is sampled on rising edges.
  - rx_data=0xFF; exactly 8 rising edges.
- start pulsed again at cycle 10 of an active transfer:
  - Ignored; exactly one done at cycle 37; busy stays 1 until done.
- rst driven low at cycle 20 mid-transfer:
  - Immediately sck=0, ss_n=2'b11, busy=0, no done; rx_data retains its prior value.
  - Next start completes normally.
- ss_sel=1 then ss_sel=3 (with NUM_SS=2, SEL_W=2):
  - First transfer asserts ss_n=2'b01.
  - Second leaves ss_n=2'b11, yet done pulses and rx_data updates.
- With SPI_LSB_FIRST_EN and lsb_first=1, tx 0x01, loopback miso=mosi:
  - mosi first bit 1, then seven 0s; rx_data=0x01.

Source files
------------

// File: rtl/spi_master_multi_if.sv
// ============================================================================
// Module : spi_master_multi_if
// Brief  : Control/serial bundle for spi_master_multi (optional SPI_LSB_FIRST_EN)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface spi_master_multi_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 2,
  parameter int SEL_W  = 1
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [SEL_W-1:0]  ss_sel;
  logic              cpol;
  logic              cpha;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first;
`endif
  logic              miso;
  logic              sck;
  logic              mosi;
  logic [NUM_SS-1:0] ss_n;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  modport master (
`ifdef SPI_LSB_FIRST_EN
    input  lsb_first,
`endif
    input  start, tx_data, ss_sel, cpol, cpha, miso,
    output sck, mosi, ss_n, busy, done, rx_data
  );

  modport slave (
`ifdef SPI_LSB_FIRST_EN
    output lsb_first,
`endif
    output start, tx_data, ss_sel, cpol, cpha, miso,
    input  sck, mosi, ss_n, busy, done, rx_data
  );
endinterface

`default_nettype wire

// File: rtl/spi_master_multi.sv
// ============================================================================
// Module : spi_master_multi
// Brief  : Parametrised 4-mode SPI master, one-hot active-low selects.
//          Define SPI_LSB_FIRST_EN to add per-transfer LSB-first ordering.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_master_multi #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_SS  = 2,
  parameter int SEL_W   = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  spi_master_multi_if.master bus
);

  localparam int c_div_w  = $clog2(CLK_DIV + 1);
  localparam int c_edge_w = $clog2(2 * DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_sck, w_sck_nxt;
  logic                r_mosi, w_mosi_nxt;
  logic [NUM_SS-1:0]   r_ss_n, w_ss_n_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic [DATA_W-1:0]   r_rx, w_rx_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic                r_cpha, w_cpha_nxt;
  logic                r_cpol, w_cpol_nxt;
  logic                r_samp, w_samp_nxt;
  logic [c_div_w-1:0]  r_div, w_div_nxt;
  logic [c_edge_w-1:0] r_edge, w_edge_nxt;

  logic                w_lsb;
  logic                w_lsb_in;
  logic                w_lsb_nxt;
  logic [NUM_SS-1:0]   w_ss_dec;
  logic                w_div_term;
  logic                w_last;
  logic                w_tx_cur;
  logic                w_tx_nxt;
  logic [DATA_W-1:0]   w_shift_miso;
  logic [DATA_W-1:0]   w_shift_samp;

`ifdef SPI_LSB_FIRST_EN
  logic r_lsb;
  assign w_lsb_in = bus.lsb_first;
  assign w_lsb    = r_lsb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lsb <= 1'b0;
    end else begin
      r_lsb <= w_lsb_nxt;
    end
  end
`else
  assign w_lsb_in = 1'b0;
  assign w_lsb    = 1'b0;
`endif

  // An out-of-range index decodes to no select, leaving all ss_n high.
  always_comb begin
    w_ss_dec = '0;
    for (int i = 0; i < NUM_SS; i++) begin
      w_ss_dec[i] = (bus.ss_sel == SEL_W'(i));
    end
  end

  assign w_div_term   = (r_div == c_div_w'(CLK_DIV - 1));
  assign w_last       = (r_edge == c_edge_w'(2 * DATA_W - 1));
  assign w_tx_cur     = w_lsb ? r_shift[0] : r_shift[DATA_W-1];
  assign w_tx_nxt     = w_lsb ? r_shift[1] : r_shift[DATA_W-2];
  assign w_shift_miso = w_lsb ? {bus.miso, r_shift[DATA_W-1:1]}
                              : {r_shift[DATA_W-2:0], bus.miso};
  assign w_shift_samp = w_lsb ? {r_samp, r_shift[DATA_W-1:1]}
                              : {r_shift[DATA_W-2:0], r_samp};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_ss_n  <= '1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rx    <= '0;
      r_shift <= '0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_samp  <= 1'b0;
      r_div   <= '0;
      r_edge  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sck   <= w_sck_nxt;
      r_mosi  <= w_mosi_nxt;
      r_ss_n  <= w_ss_n_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rx    <= w_rx_nxt;
      r_shift <= w_shift_nxt;
      r_cpol  <= w_cpol_nxt;
      r_cpha  <= w_cpha_nxt;
      r_samp  <= w_samp_nxt;
      r_div   <= w_div_nxt;
      r_edge  <= w_edge_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sck_nxt   = r_sck;
    w_mosi_nxt  = r_mosi;
    w_ss_n_nxt  = r_ss_n;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_rx_nxt    = r_rx;
    w_shift_nxt = r_shift;
    w_cpol_nxt  = r_cpol;
    w_cpha_nxt  = r_cpha;
    w_lsb_nxt   = w_lsb;
    w_samp_nxt  = r_samp;
    w_div_nxt   = r_div;
    w_edge_nxt  = r_edge;

    case (r_state)
      S_IDLE: begin
        w_sck_nxt  = bus.cpol;
        w_div_nxt  = '0;
        w_edge_nxt = '0;
        if (bus.start) begin
          w_shift_nxt = bus.tx_data;
          w_cpol_nxt  = bus.cpol;
          w_cpha_nxt  = bus.cpha;
          w_lsb_nxt   = w_lsb_in;
          w_ss_n_nxt  = ~w_ss_dec;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_SETUP;
          if (!bus.cpha) begin
            w_mosi_nxt = w_lsb_in ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
          end
        end
      end

      S_SETUP: begin
        if (w_div_term) begin
          w_div_nxt   = '0;
          w_state_nxt = S_XFER;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      S_XFER: begin
        if (w_div_term) begin
          w_div_nxt  = '0;
          w_sck_nxt  = ~r_sck;
          w_edge_nxt = r_edge + 1'b1;
          // Even count before the toggle means this edge is a leading one.
          if (!r_edge[0]) begin
            if (r_cpha) begin
              w_mosi_nxt = w_tx_cur;
            end else begin
              w_samp_nxt = bus.miso;
            end
          end else begin
            if (r_cpha) begin
              w_shift_nxt = w_shift_miso;
            end else begin
              w_shift_nxt = w_shift_samp;
              if (!w_last) begin
                w_mosi_nxt = w_tx_nxt;
              end
            end
          end
          if (w_last) begin
            w_state_nxt = S_HOLD;
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      S_HOLD: begin
        if (r_div == c_div_w'(CLK_DIV)) begin
          w_div_nxt   = '0;
          w_ss_n_nxt  = '1;
          w_busy_nxt  = 1'b0;
          w_rx_nxt    = r_shift;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.sck     = r_sck;
  assign bus.mosi    = r_mosi;
  assign bus.ss_n    = r_ss_n;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_multi.sv
// ============================================================================
// Module : tb_spi_master_multi
// Brief  : Directed self-checking bench for spi_master_multi with a slave model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_master_multi;

  localparam int DW  = 8;
  localparam int CD  = 2;
  localparam int NSS = 2;
  localparam int SW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_multi_if #(.DATA_W(DW), .NUM_SS(NSS), .SEL_W(SW)) bus ();

  spi_master_multi #(
    .DATA_W (DW),
    .CLK_DIV(CD),
    .NUM_SS (NSS),
    .SEL_W  (SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic       r_miso = 1'b0;
  bit         slv_loop = 1'b0;
  bit         slv_arm  = 1'b0;
  bit         slv_cpol = 1'b0;
  bit         slv_cpha = 1'b0;
  bit         slv_lead;
  logic [7:0] slv_word = 8'h00;
  logic [7:0] cap      = 8'h00;
  int         slv_idx  = 0;
  int         n_rise   = 0;

  int lat, n_done, ss_bad, busy_bad;

  assign bus.miso = slv_loop ? bus.mosi : r_miso;

  // Slave: samples mosi on its sampling edge, shifts miso out MSB first on the other.
  always @(bus.sck) begin
    if (slv_arm) begin
      slv_lead = (bus.sck !== slv_cpol);
      if (bus.sck === 1'b1) n_rise++;
      if (slv_lead != slv_cpha) begin
        cap = {cap[6:0], bus.mosi};
      end else if (slv_cpha) begin
        if (slv_idx < 8) r_miso = slv_word[7-slv_idx];
        slv_idx++;
      end else begin
        slv_idx++;
        if (slv_idx < 8) r_miso = slv_word[7-slv_idx];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input logic [7:0] tx, input logic [1:0] sel, input bit pol,
                     input bit pha, input logic [7:0] sw, input bit lp);
    @(negedge clk);
    bus.tx_data = tx;
    bus.ss_sel  = sel;
    bus.cpol    = pol;
    bus.cpha    = pha;
    @(negedge clk);
    slv_cpol = pol;
    slv_cpha = pha;
    slv_word = sw;
    slv_loop = lp;
    slv_idx  = 0;
    cap      = 8'h00;
    n_rise   = 0;
    r_miso   = pha ? 1'b0 : sw[7];
    slv_arm  = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [1:0] sel, input bit pol,
                      input bit pha, input logic [7:0] sw, input bit lp,
                      input int rp, input logic [1:0] ss_exp);
    arm(tx, sel, pol, pha, sw, lp);
    lat = 0; n_done = 0; ss_bad = 0; busy_bad = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        n_done++;
        if (lat == 0) lat = k;
      end
      if (lat == 0) begin
        if (bus.busy !== 1'b1) busy_bad++;
        if (bus.ss_n !== ss_exp) ss_bad++;
      end
      bus.start = (k == rp);
    end
    bus.start = 1'b0;
    slv_arm = 1'b0;
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.tx_data = 8'h00;
    bus.ss_sel  = 2'd0;
    bus.cpol    = 1'b0;
    bus.cpha    = 1'b0;
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = 1'b0;
`endif
    #2 rst = 1'b0;
    #20;
    check("rst_sck",  {31'd0, bus.sck},  32'd0);
    check("rst_mosi", {31'd0, bus.mosi}, 32'd0);
    check("rst_ss_n", {30'd0, bus.ss_n}, 32'h3);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_rx",   {24'd0, bus.rx_data}, 32'h00);
    @(negedge clk);
    rst = 1'b1;

    // Abort at cycle 20: sck is high there in mode 0.
    arm(8'h5A, 2'd0, 1'b0, 1'b0, 8'hC3, 1'b0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_sck",  {31'd0, bus.sck},  32'd0);
    check("abort_ss_n", {30'd0, bus.ss_n}, 32'h3);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_rx",   {24'd0, bus.rx_data}, 32'h00);
    @(negedge clk);
    rst = 1'b1;
    slv_arm = 1'b0;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 if (bus.done === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 32'd0);

    // Mode 0
    xfer(8'hA5, 2'd0, 1'b0, 1'b0, 8'h3C, 1'b0, 0, 2'b10);
    check("m0_latency", lat, 32'd37);
    check("m0_ndone",   n_done, 32'd1);
    check("m0_rx",      {24'd0, bus.rx_data}, 32'h3C);
    check("m0_mosi",    {24'd0, cap}, 32'hA5);
    check("m0_ss_n",    ss_bad, 32'd0);
    check("m0_busy",    busy_bad, 32'd0);
    check("m0_sck_idle", {31'd0, bus.sck}, 32'd0);
    check("m0_rises",   n_rise, 32'd8);

    // Mode 3
    xfer(8'h81, 2'd0, 1'b1, 1'b1, 8'hFF, 1'b0, 0, 2'b10);
    check("m3_latency", lat, 32'd37);
    check("m3_rx",      {24'd0, bus.rx_data}, 32'hFF);
    check("m3_mosi",    {24'd0, cap}, 32'h81);
    check("m3_rises",   n_rise, 32'd8);
    check("m3_sck_idle", {31'd0, bus.sck}, 32'd1);

    // Start re-pulsed mid-transfer
    xfer(8'h3C, 2'd0, 1'b0, 1'b0, 8'hA5, 1'b0, 10, 2'b10);
    check("rp_latency", lat, 32'd37);
    check("rp_ndone",   n_done, 32'd1);
    check("rp_busy",    busy_bad, 32'd0);
    check("rp_rx",      {24'd0, bus.rx_data}, 32'hA5);
    check("rp_mosi",    {24'd0, cap}, 32'h3C);

    // Mode 1 on slave 1
    xfer(8'h55, 2'd1, 1'b0, 1'b1, 8'h96, 1'b0, 0, 2'b01);
    check("sel1_ss_n", ss_bad, 32'd0);
    check("sel1_rx",   {24'd0, bus.rx_data}, 32'h96);
    check("sel1_mosi", {24'd0, cap}, 32'h55);

    // Mode 2, out-of-range select
    xfer(8'h0F, 2'd3, 1'b1, 1'b0, 8'h6B, 1'b0, 0, 2'b11);
    check("sel3_ss_n",  ss_bad, 32'd0);
    check("sel3_ndone", n_done, 32'd1);
    check("sel3_rx",    {24'd0, bus.rx_data}, 32'h6B);
    check("sel3_mosi",  {24'd0, cap}, 32'h0F);

`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = 1'b1;
    xfer(8'h01, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 2'b10);
    bus.lsb_first = 1'b0;
    check("lsb_mosi", {24'd0, cap}, 32'h80);
    check("lsb_rx",   {24'd0, bus.rx_data}, 32'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
